uart_tx: RTL and testbench

Oversampled UART transmitter, the transmit half of the section-2 UART. It serialises one DATA_BITS-wide word per valid/ready handshake into a frame on tx_pin: start bit, data bits LSB first, an optional odd parity bit, and one stop bit. Bit timing uses the shared tick_16x strobe from the baud generator, the same strobe used by the receiver, so both ends share one timebase.

---
 rtl/uart_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: oversampled UART transmitter.
// Sends a start bit, DATA_BITS data bits LSB first, an optional odd parity bit
// and one stop bit on tx_pin. The bit period is OVS_FACTOR tick_16x strobes.
// Optional feature macro: UART_TX_BREAK_EN adds break_req. A break holds the
// line low, then sends one bit period of mark before returning to idle.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVS_FACTOR = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_enable,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  output logic                 tx_pin,
  output logic                 tx_done
);

  // Fall back to a 1-bit counter so that a bad OVS_FACTOR reaches the fatal
  // check below instead of causing a zero-width elaboration error.
  localparam int OW = (OVS_FACTOR < 2) ? 1 : $clog2(OVS_FACTOR);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $fatal(1, "uart_tx: DATA_BITS must be 5..8");
  end
  if (OVS_FACTOR < 2 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_bad_ovs
    $fatal(1, "uart_tx: OVS_FACTOR must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK,
    S_MAB
`endif
  } state_t;

  state_t               state, state_n;
  logic [OW-1:0]        os_count, os_n;
  logic [2:0]           bit_index, bi_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_en, par_n;
  logic                 pin_n, done_n;
  logic                 bit_end;

  // The handshake is only allowed in IDLE. It does not wait for a tick.
  assign tx_ready = (state == S_IDLE);

  // The last tick of the current bit period.
  assign bit_end = tick_16x && (os_count == OW'(OVS_FACTOR - 1));

  // State and datapath registers. The reset value puts the line in mark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      os_count  <= '0;
      bit_index <= '0;
      shift_q   <= '0;
      par_en    <= 1'b0;
      tx_pin    <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      os_count  <= os_n;
      bit_index <= bi_n;
      shift_q   <= shift_n;
      par_en    <= par_n;
      tx_pin    <= pin_n;
      tx_done   <= done_n;
    end
  end

  // Next-state logic. tx_pin is computed for the state being entered, so the
  // new bit appears on the same edge that starts it.
  always_comb begin
    state_n = state;
    os_n    = os_count;
    bi_n    = bit_index;
    shift_n = shift_q;
    par_n   = par_en;
    pin_n   = tx_pin;
    done_n  = 1'b0;
    if (tick_16x)
      os_n = bit_end ? '0 : os_count + 1'b1;

    case (state)
      S_IDLE: begin
        os_n  = '0;
        pin_n = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_n = S_BREAK;
          pin_n   = 1'b0;
        end else
`endif
        if (tx_valid) begin
          shift_n = tx_data;
          par_n   = parity_enable;
          state_n = S_START;
          pin_n   = 1'b0;
        end
      end
      S_START: if (bit_end) begin
        state_n = S_DATA;
        bi_n    = '0;
        pin_n   = shift_q[0];
      end
      S_DATA: if (bit_end) begin
        if (bit_index == 3'(DATA_BITS - 1)) begin
          if (par_en) begin
            state_n = S_PARITY;
            pin_n   = ~^shift_q;
          end else begin
            state_n = S_STOP;
            pin_n   = 1'b1;
          end
        end else begin
          bi_n  = bit_index + 1'b1;
          pin_n = shift_q[bi_n];
        end
      end
      S_PARITY: if (bit_end) begin
        state_n = S_STOP;
        pin_n   = 1'b1;
      end
      S_STOP: if (bit_end) begin
        state_n = S_IDLE;
        pin_n   = 1'b1;
        done_n  = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        os_n  = '0;
        pin_n = 1'b0;
        if (!break_req) begin
          state_n = S_MAB;
          pin_n   = 1'b1;
        end
      end
      S_MAB: if (bit_end) begin
        state_n = S_IDLE;
        pin_n   = 1'b1;
      end
`endif
      default: begin
        state_n = S_IDLE;
        os_n    = '0;
        pin_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Uses the default parameters.
// tick_16x pulses once every 4 clk.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset, tick_16x, tx_valid, parity_enable;
  logic [7:0] tx_data;
  logic       tx_ready, tx_pin, tx_done;
`ifdef UART_TX_BREAK_EN
  logic       break_req;
`endif
  int vecs = 0;
  int miss = 0;

  uart_tx dut (
    .clk(clk), .reset(reset), .tick_16x(tick_16x), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .parity_enable(parity_enable),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx_pin(tx_pin), .tx_done(tx_done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one clk with the given tick value, then samples 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick_16x = t;
    @(posedge clk);
    #1;
    tick_16x = 1'b0;
  endtask

  task automatic do_tick();
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
  endtask

  // Checks that the line holds exp and the block stays busy for n ticks.
  task automatic hold(input string tag, input logic exp, input int n);
    repeat (n) begin
      chk({tag, "_pin"}, tx_pin, exp);
      chk({tag, "_busy"}, tx_ready, 1'b0);
      chk({tag, "_nodone"}, tx_done, 1'b0);
      do_tick();
    end
  endtask

  // bits[0] is the first bit on the line. Each bit lasts 16 ticks.
  task automatic frame(input string tag, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) hold(tag, bits[i], 16);
  endtask

  task automatic frame_end(input string tag);
    chk({tag, "_done"}, tx_done, 1'b1);
    chk({tag, "_ready"}, tx_ready, 1'b1);
    chk({tag, "_idlepin"}, tx_pin, 1'b1);
  endtask

  initial begin
    reset = 1'b1; tick_16x = 1'b0; tx_valid = 1'b0; parity_enable = 1'b0;
    tx_data = 8'h00;
`ifdef UART_TX_BREAK_EN
    break_req = 1'b0;
`endif
    @(posedge clk); #1;
    chk("rst_pin", tx_pin, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_done", tx_done, 1'b0);
    reset = 1'b0;
    cyc(1'b1); cyc(1'b0);
    chk("idle_pin", tx_pin, 1'b1);

    // 1: 0x55 without parity, 10 bits, 160 ticks
    tx_data = 8'h55; tx_valid = 1'b1;
    cyc(1'b0);
    tx_valid = 1'b0;
    chk("t1_start", tx_pin, 1'b0);
    frame("t1", 16'({1'b1, 8'h55, 1'b0}), 10);
    frame_end("t1");
    cyc(1'b0);
    chk("t1_done_once", tx_done, 1'b0);

    // 2: 0xA3 with odd parity. 0xA3 has four ones, so the parity bit is 1.
    tx_data = 8'hA3; parity_enable = 1'b1; tx_valid = 1'b1;
    cyc(1'b0);
    tx_valid = 1'b0; parity_enable = 1'b0;
    frame("t2", 16'({1'b1, 1'b1, 8'hA3, 1'b0}), 11);
    frame_end("t2");
    cyc(1'b0);

    // 3: back-to-back frames with tx_valid held high
    tx_data = 8'h01; tx_valid = 1'b1;
    cyc(1'b0);
    tx_data = 8'h00;             // changes while busy have no effect
    frame("t3a", 16'({1'b1, 8'h01, 1'b0}), 10);
    frame_end("t3a");
    tx_data = 8'hFF;
    cyc(1'b0);
    chk("t3_b2b_start", tx_pin, 1'b0);
    chk("t3_b2b_busy", tx_ready, 1'b0);
    chk("t3_b2b_done_clr", tx_done, 1'b0);
    frame("t3b", 16'({1'b1, 8'hFF, 1'b0}), 10);
    frame_end("t3b");
    tx_valid = 1'b0;
    cyc(1'b0);
    chk("t3_idle_ready", tx_ready, 1'b1);
    chk("t3_idle_pin", tx_pin, 1'b1);

    // 4: reset during data bit 3 of 0x0F, then send 0x81 cleanly
    tx_data = 8'h0F; tx_valid = 1'b1;
    cyc(1'b0);
    tx_valid = 1'b0;
    frame("t4a", 16'b1110, 4);
    hold("t4_bit3", 1'b1, 5);
    reset = 1'b1;
    #1;
    chk("t4_rst_pin", tx_pin, 1'b1);
    chk("t4_rst_ready", tx_ready, 1'b1);
    chk("t4_rst_done", tx_done, 1'b0);
    cyc(1'b1); cyc(1'b0);
    reset = 1'b0;
    repeat (3) begin
      do_tick();
      chk("t4_post_nodone", tx_done, 1'b0);
      chk("t4_post_ready", tx_ready, 1'b1);
      chk("t4_post_pin", tx_pin, 1'b1);
    end
    tx_data = 8'h81; tx_valid = 1'b1;
    cyc(1'b0);
    tx_valid = 1'b0;
    frame("t4b", 16'({1'b1, 8'h81, 1'b0}), 10);
    frame_end("t4b");
    cyc(1'b0);

    // 5: tick gated off for 100 clk after 7 ticks of the start bit
    tx_data = 8'hC5; tx_valid = 1'b1;
    cyc(1'b0);
    tx_valid = 1'b0;
    hold("t5_pre", 1'b0, 7);
    repeat (100) begin
      cyc(1'b0);
      chk("t5_frozen_pin", tx_pin, 1'b0);
    end
    hold("t5_rest", 1'b0, 9);
    frame("t5", 16'({1'b1, 8'hC5}), 9);
    frame_end("t5");
    cyc(1'b0);

`ifdef UART_TX_BREAK_EN
    // 6: a break wins over tx_valid. The line is low for 40 ticks, then high
    // for 16 ticks, and then the word is accepted.
    tx_data = 8'h5A; tx_valid = 1'b1; break_req = 1'b1;
    cyc(1'b0);
    hold("t6_break", 1'b0, 40);
    break_req = 1'b0;
    cyc(1'b0);
    hold("t6_mab", 1'b1, 16);
    chk("t6_ready", tx_ready, 1'b1);
    cyc(1'b0);
    tx_valid = 1'b0;
    frame("t6", 16'({1'b1, 8'h5A, 1'b0}), 10);
    frame_end("t6");
    cyc(1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
